// File: rtl/keccak_padder_param_if.sv
// keccak_padder_param_if
// Bundles the message-input and block-output handshakes of the Keccak padder.
//   master : message source / permutation core side (drives in, in_ready,
//            is_last, byte_num, f_ack; observes buffer_full, out, out_ready,
//            last_block)
//   slave  : the padder itself
// IN_BYTES and RATE must match the padder instance connected to it.
interface keccak_padder_param_if #(
  parameter int IN_BYTES = 4,
  parameter int RATE     = 576
);
  localparam int W    = 8 * IN_BYTES;
  localparam int BN_W = $clog2(IN_BYTES);

  logic [W-1:0]    in;
  logic            in_ready;
  logic            is_last;
  logic [BN_W-1:0] byte_num;
  logic            buffer_full;
  logic [RATE-1:0] out;
  logic            out_ready;
  logic            last_block;
  logic            f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, last_block
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, last_block
  );
endinterface

// File: rtl/keccak_padder_param.sv
// keccak_padder_param
// Packs a stream of IN_BYTES-wide message words into RATE-bit blocks and
// applies Keccak multi-rate padding (PAD_BYTE ... 0x80) to the final block.
// Ports:
//   clk   : clock, everything on the rising edge
//   reset : synchronous, active-high; returns to ACCEPT with an empty block
//   bus   : keccak_padder_param_if.slave
//             in/in_ready/is_last/byte_num : message word input
//             buffer_full                  : input is not being taken
//             out/out_ready/last_block     : completed block to the core
//             f_ack                        : core has consumed the block
// All outputs come straight from registers.
module keccak_padder_param #(
  parameter int         IN_BYTES = 4,
  parameter int         RATE     = 576,
  parameter logic [7:0] PAD_BYTE = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset,
  keccak_padder_param_if.slave  bus
);
  localparam int W     = 8 * IN_BYTES;
  localparam int WORDS = RATE / W;
  localparam int BN_W  = $clog2(IN_BYTES);
  localparam int CNT_W = $clog2(WORDS + 1);

  typedef enum logic [1:0] {ACCEPT, PAD, FULL, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [RATE-1:0] block_reg, block_next;
  logic            last_reg, last_next;
  logic [W-1:0]    pad_word;
  logic [W-1:0]    word;
  logic            last_slot;

  assign last_slot = (cnt_reg == CNT_W'(WORDS - 1));

  // Final word: keep bytes before byte_num, put PAD_BYTE at byte_num and zero
  // the rest. Byte 0 is the most significant byte of the word.
  for (genvar gi = 0; gi < IN_BYTES; gi++) begin : g_pad_byte
    localparam logic [BN_W-1:0] IDX = BN_W'(gi);
    assign pad_word[W-1-8*gi -: 8] =
        (IDX < bus.byte_num)  ? bus.in[W-1-8*gi -: 8] :
        (IDX == bus.byte_num) ? PAD_BYTE : 8'h00;
  end

  // Words are shifted in at the bottom, so after WORDS shifts the first
  // word sits at the top of the block and the last word at the bottom.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    block_next = block_reg;
    last_next  = last_reg;
    word       = '0;
    case (state_reg)
      ACCEPT: begin
        if (bus.in_ready) begin
          word = bus.is_last ? pad_word : bus.in;
          // The closing 0x80 merges with the pad byte when both land in the
          // final byte of the block.
          if (bus.is_last && last_slot) word[7:0] = word[7:0] | 8'h80;
          block_next = {block_reg[RATE-W-1:0], word};
          cnt_next   = cnt_reg + CNT_W'(1);
          if (last_slot) begin
            state_next = FULL;
            last_next  = bus.is_last;
          end else if (bus.is_last) begin
            state_next = PAD;
          end
        end
      end
      PAD: begin
        word       = last_slot ? W'(8'h80) : '0;
        block_next = {block_reg[RATE-W-1:0], word};
        cnt_next   = cnt_reg + CNT_W'(1);
        if (last_slot) begin
          state_next = FULL;
          last_next  = 1'b1;
        end
      end
      FULL: begin
        if (bus.f_ack) begin
          cnt_next   = '0;
          block_next = '0;
          last_next  = 1'b0;
          state_next = last_reg ? DONE : ACCEPT;
        end
      end
      DONE: begin
        // Message finished; only reset leaves this state.
      end
      default: state_next = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ACCEPT;
      cnt_reg   <= '0;
      block_reg <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      block_reg <= block_next;
      last_reg  <= last_next;
    end
  end

  assign bus.buffer_full = (state_reg != ACCEPT);
  assign bus.out         = block_reg;
  assign bus.out_ready   = (state_reg == FULL);
  assign bus.last_block  = last_reg;
endmodule

// File: tb/tb_keccak_padder_param.sv
module tb_keccak_padder_param;
  localparam int RB      = 72;   // bytes per block, instance A
  localparam int WORDS_A = 18;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  keccak_padder_param_if #(.IN_BYTES(4), .RATE(576))  bus_a();
  keccak_padder_param_if #(.IN_BYTES(8), .RATE(1088)) bus_b();

  keccak_padder_param #(.IN_BYTES(4), .RATE(576), .PAD_BYTE(8'h01)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a));
  keccak_padder_param #(.IN_BYTES(8), .RATE(1088), .PAD_BYTE(8'h06)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b));

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Behavioural model of instance A: the block is a list of message bytes,
  // padding is appended as bytes, and the pad phase is a countdown.
  logic [7:0]   m_q[$];
  bit           m_full, m_last, m_done, m_acc;
  int           m_pad_wait;
  logic [575:0] m_block;

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_block();
    for (int i = 0; i < RB; i++) m_block[575-8*i -: 8] = m_q[i];
  endtask

  task automatic model_step();
    int slot;
    m_acc = 0;
    if (rst_a) begin
      m_q.delete(); m_full = 0; m_last = 0; m_done = 0; m_pad_wait = 0; m_block = '0;
    end else if (m_done) begin
      m_acc = 0;
    end else if (m_full) begin
      if (bus_a.f_ack) begin
        m_full = 0; m_block = '0; m_q.delete();
        if (m_last) m_done = 1;
        m_last = 0;
      end
    end else if (m_pad_wait > 0) begin
      m_pad_wait--;
      if (m_pad_wait == 0) m_full = 1;
    end else if (bus_a.in_ready) begin
      m_acc = 1;
      if (!bus_a.is_last) begin
        for (int b = 0; b < 4; b++) m_q.push_back(bus_a.in[31-8*b -: 8]);
        if (m_q.size() == RB) begin
          build_block(); m_full = 1; m_last = 0;
        end
      end else begin
        slot = m_q.size() / 4;
        for (int b = 0; b < int'(bus_a.byte_num); b++) m_q.push_back(bus_a.in[31-8*b -: 8]);
        m_q.push_back(8'h01);
        while (m_q.size() < RB) m_q.push_back(8'h00);
        m_q[RB-1] = m_q[RB-1] | 8'h80;
        build_block();
        m_last = 1;
        m_pad_wait = WORDS_A - 1 - slot;
        if (m_pad_wait == 0) m_full = 1;
      end
    end
  endtask

  // Compare process: every cycle, DUT A against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("buffer_full", bus_a.buffer_full, (m_full || m_done || m_pad_wait > 0));
      check("out_ready", bus_a.out_ready, m_full);
      check("last_block", bus_a.last_block, (m_full && m_last));
      if (m_full) check("out", bus_a.out, m_block);
    end
  end

  task automatic tick(input logic rst, input logic inr, input logic lst,
                      input logic [31:0] w, input logic [1:0] bn, input logic ack);
    @(negedge clk);
    #2;
    rst_a = rst; bus_a.in_ready = inr; bus_a.is_last = lst;
    bus_a.in = w; bus_a.byte_num = bn; bus_a.f_ack = ack;
    model_step();
    chk_en = 1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic send(input logic [31:0] w, input logic lst, input logic [1:0] bn);
    tick(1'b0, 1'b1, lst, w, bn, 1'b0);
  endtask

  task automatic wait_ready_a(input string name, input int exp_lat);
    int lat;
    idle();
    lat = 0;
    while (!bus_a.out_ready && lat < 100) begin
      idle();
      lat++;
    end
    check(name, 576'(lat), 576'(exp_lat));
  endtask

  task automatic tick_b(input logic rst, input logic inr, input logic lst);
    @(negedge clk);
    #2;
    rst_b = rst; bus_b.in_ready = inr; bus_b.is_last = lst;
    bus_b.in = {$urandom, $urandom}; bus_b.byte_num = 3'd0; bus_b.f_ack = 1'b0;
  endtask

  initial begin
    int lat, idx, n, budget;
    logic inr, lst, ack;
    logic [1:0] bn;

    bus_a.in = '0; bus_a.in_ready = 0; bus_a.is_last = 0; bus_a.byte_num = '0; bus_a.f_ack = 0;
    bus_b.in = '0; bus_b.in_ready = 0; bus_b.is_last = 0; bus_b.byte_num = '0; bus_b.f_ack = 0;

    // "Hello, world" then an empty last word.
    tick(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    idle();
    check("reset out", bus_a.out, 576'h0);
    check("reset buffer_full", bus_a.buffer_full, 1'b0);
    send(32'h48656C6C, 1'b0, 2'd0);
    send(32'h6F2C2077, 1'b0, 2'd0);
    send(32'h6F726C64, 1'b0, 2'd0);
    send(32'h00000000, 1'b1, 2'd0);
    wait_ready_a("hello latency", 14);
    check("hello text", bus_a.out[575:480], 96'h48656C6C6F2C20776F726C64);
    check("hello pad byte", bus_a.out[479:472], 8'h01);
    check("hello zeros", bus_a.out[471:8], 464'h0);
    check("hello end byte", bus_a.out[7:0], 8'h80);
    check("hello last_block", bus_a.last_block, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    // After the final ack the padder stays closed under in_ready.
    for (int i = 0; i < 10; i++) begin
      send($urandom, 1'b0, 2'd0);
      check("done buffer_full", bus_a.buffer_full, 1'b1);
      check("done out_ready", bus_a.out_ready, 1'b0);
    end

    // 17 words then "dog " with 3 valid bytes: pad and end merge into 0x81.
    tick(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    for (int i = 0; i < 17; i++) send($urandom, 1'b0, 2'd0);
    send(32'h646F6720, 1'b1, 2'd3);
    wait_ready_a("dog latency", 0);
    check("dog tail", bus_a.out[31:0], 32'h646F6781);
    check("dog last_block", bus_a.last_block, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

    // Two-block message with words dropped while the first block waits.
    tick(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    for (int i = 0; i < 18; i++) send($urandom, 1'b0, 2'd0);
    idle();
    check("blk1 out_ready", bus_a.out_ready, 1'b1);
    check("blk1 last_block", bus_a.last_block, 1'b0);
    check("blk1 buffer_full", bus_a.buffer_full, 1'b1);
    send($urandom, 1'b0, 2'd0);
    send($urandom, 1'b0, 2'd0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    send($urandom, 1'b0, 2'd0);
    send($urandom, 1'b0, 2'd0);
    send(32'hAABBCCDD, 1'b1, 2'd2);
    wait_ready_a("blk2 latency", 15);
    check("blk2 bytes", bus_a.out[511:488], 24'hAABB01);
    check("blk2 last_block", bus_a.last_block, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

    // Reset while padding with five words in the block.
    tick(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) send($urandom, 1'b0, 2'd0);
    send($urandom, 1'b1, 2'd1);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    idle();
    check("pad reset out", bus_a.out, 576'h0);
    check("pad reset out_ready", bus_a.out_ready, 1'b0);
    check("pad reset buffer_full", bus_a.buffer_full, 1'b0);
    send(32'h48656C6C, 1'b0, 2'd0);
    send(32'h00000000, 1'b1, 2'd0);
    wait_ready_a("fresh latency", 16);
    check("fresh head", bus_a.out[575:536], 40'h48656C6C01);
    check("fresh end byte", bus_a.out[7:0], 8'h80);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

    // Randomized messages of 0..40 words with gaps, drops and stray acks.
    for (int m = 0; m < 25; m++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
      n = $urandom_range(0, 40);
      idx = 0;
      budget = 0;
      while (!m_done && budget < 3000) begin
        inr = ($urandom_range(0, 3) != 0);
        lst = (idx == n);
        bn  = 2'($urandom_range(0, 3));
        ack = ($urandom_range(0, 2) == 0);
        tick(1'b0, inr, lst, $urandom, bn, ack);
        if (m_acc) idx++;
        budget++;
      end
      check("random message completes", m_done, 1'b1);
      for (int i = 0; i < 3; i++) send($urandom, 1'b0, 2'd0);
    end
    idle();

    // Wide instance: empty SHA3 message, 17-word block.
    tick_b(1'b1, 1'b0, 1'b0);
    tick_b(1'b0, 1'b1, 1'b1);
    tick_b(1'b0, 1'b0, 1'b0);
    lat = 0;
    while (!bus_b.out_ready && lat < 100) begin
      tick_b(1'b0, 1'b0, 1'b0);
      lat++;
    end
    check("b latency", 576'(lat), 576'(16));
    check("b first byte", bus_b.out[1087:1080], 8'h06);
    check("b middle zero", |bus_b.out[1079:8], 1'b0);
    check("b end byte", bus_b.out[7:0], 8'h80);
    check("b last_block", bus_b.last_block, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
